// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path:
// opcodes, funct codes, ALU codes and FSM state encodings.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// R-type funct to ALU control decoder; also used by the
// single-cycle decoder path.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  always_comb begin
    alucontrol = ALU_ADD;
    illegal    = 1'b0;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLT:  alucontrol = ALU_SLT;
      default: illegal    = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM driving a shared-memory,
// single-ALU datapath with a memory-ready stall handshake.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1,
  parameter bit ILLEGAL_TRAP  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_t     state, state_nxt;
  logic       ready;
  logic       op_known;
  logic       pcwrite;
  logic       branch;
  logic [2:0] fn_alu;
  logic       fn_bad;

  alu_decoder u_alu_dec (
    .funct      (funct),
    .alucontrol (fn_alu),
    .illegal    (fn_bad)
  );

  assign ready   = !USE_MEM_READY || mem_ready;
  assign state_o = state;

  always_comb begin
    op_known = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW,
      OP_BEQ, OP_ADDI, OP_J: op_known = 1'b1;
      default:               op_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:
        state_nxt = ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXECUTE;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_FETCH;
        endcase
      S_MEMADR:
        if (op == OP_LW)      state_nxt = S_MEMREAD;
        else if (op == OP_SW) state_nxt = S_MEMWRITE;
        else                  state_nxt = S_FETCH;
      S_MEMREAD:
        state_nxt = ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE:
        state_nxt = ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE: state_nxt = S_ALUWB;
      S_ADDIEX:  state_nxt = S_ADDIWB;
      default:   state_nxt = S_FETCH;
    endcase
  end

  // While reset is high every strobe is forced low, even in FETCH.
  always_comb begin
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = ALU_ADD;
    pcsrc      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          alusrcb = 2'b01;
          irwrite = ready;
          pcwrite = ready;
        end
        S_DECODE: begin
          alusrcb    = 2'b11;
          illegal_op = ILLEGAL_TRAP && !op_known;
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_EXECUTE: begin
          alusrca    = 1'b1;
          alucontrol = fn_alu;
          illegal_op = ILLEGAL_TRAP && fn_bad;
        end
        S_ALUWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        S_BRANCH: begin
          alusrca    = 1'b1;
          alucontrol = ALU_SUB;
          pcsrc      = 2'b01;
          branch     = 1'b1;
        end
        S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_ADDIWB: regwrite = 1'b1;
        S_JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_en = pcwrite || (branch && zero);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: per-instruction cycle plans are queued as
// they are issued and a negedge monitor compares DUT outputs.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, iord, memwrite, irwrite, regwrite;
  logic       regdst, memtoreg, alusrca, pc_en, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_o;

  int n_chk  = 0;
  int n_pass = 0;
  int n_cyc  = 0;
  logic [20:0] exp_q[$];

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .alucontrol (alucontrol),
    .pcsrc      (pcsrc),
    .pc_en      (pc_en),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  function automatic logic [20:0] pk(
    input logic [3:0] st, input logic mreq, io, mw, ir, rw,
    input logic rd, m2r, sa, input logic [1:0] sb,
    input logic [2:0] ac, input logic [1:0] ps,
    input logic pe, il);
    return {mreq, io, mw, ir, rw, rd, m2r, sa,
            sb, ac, ps, pe, il, st};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic known(input logic [5:0] o);
    return o == 6'b000000 || o == 6'b100011 ||
           o == 6'b101011 || o == 6'b000100 ||
           o == 6'b001000 || o == 6'b000010;
  endfunction

  function automatic void ref_alu(input logic [5:0] f,
    output logic [2:0] ac, output logic il);
    il = 1'b0;
    case (f)
      6'b100000: ac = 3'b010;
      6'b100010: ac = 3'b110;
      6'b100100: ac = 3'b000;
      6'b100101: ac = 3'b001;
      6'b101010: ac = 3'b111;
      default: begin ac = 3'b010; il = 1'b1; end
    endcase
  endfunction

  localparam logic [20:0] RV =
    {8'b0, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0, 4'd0};

  always @(negedge clk) begin
    logic [20:0] act, e;
    n_cyc++;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {mem_req, iord, memwrite, irwrite, regwrite,
             regdst, memtoreg, alusrca, alusrcb, alucontrol,
             pcsrc, pc_en, illegal_op, state_o};
      n_chk++;
      if (act === e) n_pass++;
      else $display("FAIL outputs cycle %0d: got %h want %h",
                    n_cyc, act, e);
    end
  end

  task automatic cyc(input logic r, mr, z,
    input logic [5:0] o, f, input logic [20:0] e);
    @(posedge clk); #1;
    reset = r; mem_ready = mr; zero = z;
    op = o; funct = f;
    exp_q.push_back(e);
  endtask

  task automatic fetch(input logic [5:0] o, f, input int fw);
    for (int i = 0; i < fw; i++)
      cyc(0, 0, rb(), o, f,
          pk(0, 1,0,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0, 0));
    cyc(0, 1, rb(), o, f,
        pk(0, 1,0,0,1,0,0,0,0, 2'b01, 3'b010, 2'b00, 1, 0));
  endtask

  task automatic run_instr(input logic [5:0] o, f,
    input int fw, mw, input logic z);
    logic il;
    logic [2:0] ac;
    fetch(o, f, fw);
    il = !known(o);
    cyc(0, rb(), rb(), o, f,
        pk(1, 0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0, il));
    if (il) return;
    if (o == 6'b100011 || o == 6'b101011)
      cyc(0, rb(), rb(), o, f,
          pk(2, 0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0, 0));
    case (o)
      6'b100011: begin
        for (int i = 0; i <= mw; i++)
          cyc(0, logic'(i == mw), rb(), o, f,
              pk(3, 1,1,0,0,0,0,0,0, 2'b00, 3'b010, 2'b00, 0, 0));
        cyc(0, rb(), rb(), o, f,
            pk(4, 0,0,0,0,1,0,1,0, 2'b00, 3'b010, 2'b00, 0, 0));
      end
      6'b101011:
        for (int i = 0; i <= mw; i++)
          cyc(0, logic'(i == mw), rb(), o, f,
              pk(5, 1,1,1,0,0,0,0,0, 2'b00, 3'b010, 2'b00, 0, 0));
      6'b000000: begin
        ref_alu(f, ac, il);
        cyc(0, rb(), rb(), o, f,
            pk(6, 0,0,0,0,0,0,0,1, 2'b00, ac, 2'b00, 0, il));
        cyc(0, rb(), rb(), o, f,
            pk(7, 0,0,0,0,1,1,0,0, 2'b00, 3'b010, 2'b00, 0, 0));
      end
      6'b000100:
        cyc(0, rb(), z, o, f,
            pk(8, 0,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, z, 0));
      6'b001000: begin
        cyc(0, rb(), rb(), o, f,
            pk(9, 0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0, 0));
        cyc(0, rb(), rb(), o, f,
            pk(10, 0,0,0,0,1,0,0,0, 2'b00, 3'b010, 2'b00, 0, 0));
      end
      default:
        cyc(0, rb(), rb(), o, f,
            pk(11, 0,0,0,0,0,0,0,0, 2'b00, 3'b010, 2'b10, 1, 0));
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] o, f;
    logic [5:0] fns[5];
    fns = '{6'b100000, 6'b100010, 6'b100100,
            6'b100101, 6'b101010};

    for (int i = 0; i < 3; i++)
      cyc(1, 1, 0, OP_LW, 6'd0, RV);

    run_instr(OP_LW,   6'd0,      0, 0, 0);
    run_instr(OP_LW,   6'd0,      0, 0, 0);
    run_instr(OP_SW,   6'd0,      0, 3, 0);
    run_instr(OP_RTYPE, 6'b101010, 0, 0, 0);
    run_instr(OP_RTYPE, 6'b111111, 0, 0, 0);
    run_instr(OP_BEQ,  6'd0,      0, 0, 1);
    run_instr(OP_BEQ,  6'd0,      0, 0, 0);
    run_instr(6'b111111, 6'd0,    1, 0, 0);
    run_instr(OP_J,    6'd0,      2, 0, 0);
    run_instr(OP_ADDI, 6'd0,      0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 6))
        0: o = OP_RTYPE;
        1: o = OP_LW;
        2: o = OP_SW;
        3: o = OP_BEQ;
        4: o = OP_ADDI;
        5: o = OP_J;
        default: begin
          o = 6'($urandom);
          while (known(o)) o = 6'($urandom);
        end
      endcase
      if ($urandom_range(0, 4) == 0) f = 6'($urandom);
      else f = fns[$urandom_range(0, 4)];
      run_instr(o, f, $urandom_range(0, 2),
                $urandom_range(0, 2), rb());
    end

    // Abort a load while it waits in MEMREAD.
    fetch(OP_LW, 6'd0, 0);
    cyc(0, 1, 0, OP_LW, 6'd0,
        pk(1, 0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0, 0));
    cyc(0, 1, 0, OP_LW, 6'd0,
        pk(2, 0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0, 0));
    cyc(0, 0, 0, OP_LW, 6'd0,
        pk(3, 1,1,0,0,0,0,0,0, 2'b00, 3'b010, 2'b00, 0, 0));
    cyc(1, 1, 0, OP_LW, 6'd0, RV);
    cyc(1, 1, 0, OP_LW, 6'd0, RV);
    run_instr(OP_ADDI, 6'd0, 0, 0, 0);
    run_instr(OP_SW,   6'd0, 1, 1, 0);

    @(negedge clk); #1;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d left want 0",
                  exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
